// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect
// and the valid/ready hand-off to decode.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;

    // Fetch stage side.
    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instruction, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               if_ready
    );

    // Memory / execute / decode side.
    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instruction, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
               if_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// hands the returned word to decode; redirects flush any in-flight response.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_fetch_if.master  bus
);

    typedef enum logic [1:0] {StReq, StWait, StHold, StFlush} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            if_pc_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            if_pc_q <= if_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;

        if (bus.redirect_valid) begin
            pc_d    = {bus.redirect_pc[31:2], 2'b00};
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            unique case (state_q)
                // An accepted old-address request still owes a response; flush it.
                StReq:   state_d = bus.imem_req_ready ? StFlush : StReq;
                StWait:  state_d = bus.imem_rsp_valid ? StReq : StFlush;
                StHold:  state_d = StReq;
                StFlush: state_d = bus.imem_rsp_valid ? StReq : StFlush;
                default: state_d = StReq;
            endcase
        end else begin
            unique case (state_q)
                StReq: begin
                    if (bus.imem_req_ready) state_d = StWait;
                end
                StWait: begin
                    if (bus.imem_rsp_valid) begin
                        instr_d = bus.imem_rsp_data;
                        if_pc_d = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + 32'd4;
                        state_d = StHold;
                    end
                end
                StHold: begin
                    if (bus.if_ready) begin
                        valid_d = 1'b0;
                        instr_d = NOP_INSTR;
                        state_d = StReq;
                    end
                end
                StFlush: begin
                    if (bus.imem_rsp_valid) state_d = StReq;
                end
                default: state_d = StReq;
            endcase
        end
    end

    assign bus.imem_req_valid = rst_n && (state_q == StReq);
    assign bus.imem_addr      = pc_q;
    assign bus.if_valid       = valid_q;
    assign bus.if_instruction = instr_q;
    assign bus.if_pc          = if_pc_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, fetch, backpressure, redirects,
// PC wrap and reset while a response is outstanding.
module tb_instruction_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC  (32'h0000_0100),
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.if_ready       = 1'b0;

        step();
        step();
        check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check("rst_if_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst_instr", bus.if_instruction, NOP);
        check("rst_if_pc", bus.if_pc, 32'h0);

        // First fetch from RESET_PC
        rst_n = 1'b1;
        #1;
        check("req_valid_first", {31'b0, bus.imem_req_valid}, 32'd1);
        check("addr_first", bus.imem_addr, 32'h100);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        check("wait_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0050_0093;
        step();
        bus.imem_rsp_valid = 1'b0;
        check("hold_valid", {31'b0, bus.if_valid}, 32'd1);
        check("hold_instr", bus.if_instruction, 32'h0050_0093);
        check("hold_pc", bus.if_pc, 32'h100);

        // Backpressure for five cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {31'b0, bus.if_valid}, 32'd1);
            check("bp_instr", bus.if_instruction, 32'h0050_0093);
            check("bp_pc", bus.if_pc, 32'h100);
            check("bp_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        end
        bus.if_ready = 1'b1;
        step();
        bus.if_ready = 1'b0;
        check("accept_valid", {31'b0, bus.if_valid}, 32'd0);
        check("accept_instr", bus.if_instruction, NOP);
        check("accept_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("accept_addr", bus.imem_addr, 32'h104);

        // Redirect during WAIT, then stale response flushed
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h2003;
        step();
        bus.redirect_valid = 1'b0;
        check("flush_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        bus.imem_rsp_valid = 1'b0;
        check("flush_if_valid", {31'b0, bus.if_valid}, 32'd0);
        check("flush_instr", bus.if_instruction, NOP);
        check("flush_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("flush_addr", bus.imem_addr, 32'h2000);

        // Redirect coincident with response in WAIT
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1234_5678;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h400;
        step();
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        check("coinc_if_valid", {31'b0, bus.if_valid}, 32'd0);
        check("coinc_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("coinc_addr", bus.imem_addr, 32'h400);

        // Redirect in REQ without acceptance, then PC wrap
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        check("wrap_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0010_0113;
        step();
        bus.imem_rsp_valid = 1'b0;
        check("wrap_if_pc", bus.if_pc, 32'hFFFF_FFFC);
        check("wrap_instr", bus.if_instruction, 32'h0010_0113);
        bus.if_ready = 1'b1;
        step();
        bus.if_ready = 1'b0;
        check("wrap_next_addr", bus.imem_addr, 32'h0);

        // Reset while WAIT, stale response after release ignored
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        check("rst2_no_req", {31'b0, bus.imem_req_valid}, 32'd0);
        rst_n              = 1'b1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hCAFE_F00D;
        step();
        bus.imem_rsp_valid = 1'b0;
        check("rst2_if_valid", {31'b0, bus.if_valid}, 32'd0);
        check("rst2_instr", bus.if_instruction, NOP);
        check("rst2_req", {31'b0, bus.imem_req_valid}, 32'd1);
        check("rst2_addr", bus.imem_addr, 32'h100);

        // Redirect while HOLD drops the held instruction
        bus.imem_req_ready = 1'b1;
        step();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0533;
        step();
        bus.imem_rsp_valid = 1'b0;
        check("hold2_valid", {31'b0, bus.if_valid}, 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        step();
        bus.redirect_valid = 1'b0;
        check("hredir_valid", {31'b0, bus.if_valid}, 32'd0);
        check("hredir_instr", bus.if_instruction, NOP);
        check("hredir_addr", bus.imem_addr, 32'h300);
        check("hredir_req", {31'b0, bus.imem_req_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
